suma_acumulador: RTL

- Pipelined multi-channel summation block for the oversampled acquisition path.
- Each valid beat, it sums NCH parallel unsigned channel samples in a registered binary adder tree.
- It then accumulates those per-beat sums over one frame of SAMPLES*OSF valid beats.
- It emits the frame total with a one-cycle valid pulse and restarts automatically for the next frame.

---
 rtl/suma_acumulador.sv | 120 ++++++++++++
 1 files changed

// File: rtl/suma_acumulador.sv
// suma_acumulador: pipelined NCH-channel adder tree feeding a frame accumulator.
// Each valid beat sums NCH unsigned samples; SAMPLES*OSF valid beats form one
// frame, whose total is emitted with a single-cycle out_valid pulse.
module suma_acumulador #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int SIZE    = 16,
  parameter int NCH     = 4,
  localparam int N      = SAMPLES * OSF,
  localparam int LVL    = $clog2(NCH),
  localparam int TW     = SIZE + 1 + LVL,
  localparam int W      = TW + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [NCH*(SIZE+1)-1:0] in_data,
  input  logic                    clear,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic                    busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  // Per-level "a stage holds a valid beat" flags; level 0 is the raw input,
  // not a register, so it never contributes to busy.
  logic [LVL:0] pipe_v;

  // Level l holds NCH>>l partial sums of SIZE+1+l bits; level 0 is the input.
  for (genvar l = 0; l <= LVL; l++) begin : lvl
    logic [SIZE+l:0] sum [NCH>>l];
    logic            v;

    if (l == 0) begin : g_in
      for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign sum[k] = in_data[k*(SIZE+1) +: SIZE+1];
      end
      // A beat presented together with clear is dropped here.
      assign v         = in_valid & ~clear;
      assign pipe_v[l] = 1'b0;
    end else begin : g_add
      // Pairwise add of the previous level, valid bit travelling alongside.
      always_ff @(posedge clk) begin
        if (rst) begin
          v <= 1'b0;
          for (int unsigned j = 0; j < (NCH >> l); j++) begin
            sum[j] <= '0;
          end
        end else begin
          v <= clear ? 1'b0 : lvl[l-1].v;
          for (int unsigned j = 0; j < (NCH >> l); j++) begin
            sum[j] <= {1'b0, lvl[l-1].sum[2*j]} + {1'b0, lvl[l-1].sum[2*j+1]};
          end
        end
      end
      assign pipe_v[l] = v;
    end
  end

  logic [TW-1:0] tree_sum;
  logic          tree_valid;

  assign tree_sum   = lvl[LVL].sum[0];
  assign tree_valid = lvl[LVL].v;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [W-1:0]  acc;

  // Frame accumulator: first beat loads, middle beats add, last beat emits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_valid) begin
        case (state)
          IDLE: begin
            if (N == 1) begin
              out_data  <= W'(tree_sum);
              out_valid <= 1'b1;
            end else begin
              acc   <= W'(tree_sum);
              count <= CW'(1);
              state <= ACC;
            end
          end
          default: begin
            if (count == CW'(N - 1)) begin
              out_data  <= acc + W'(tree_sum);
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= IDLE;
            end else begin
              acc   <= acc + W'(tree_sum);
              count <= count + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign busy = (count != '0) | (|pipe_v);

endmodule
